// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared baud encoding, tick terminal counts and rx FSM states
package uart_pkg;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    // Terminal counts for a 50 MHz clock at 16x oversampling.
    localparam int TC_2400  = 1301;
    localparam int TC_4800  = 650;
    localparam int TC_9600  = 325;
    localparam int TC_19200 = 162;

    localparam int TC_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Rounded divisor minus one; reproduces the constants above at 50 MHz / 16x.
    function automatic int tick_terminal(input int clk_hz, input int oversample, input int baud);
        int div;
        div = baud * oversample;
        return ((clk_hz + div / 2) / div) - 1;
    endfunction

endpackage

// File: rtl/baud_tick_rx.sv
// rtl/baud_tick_rx.sv - oversample tick generator, restartable so sampling aligns to the start edge
module baud_tick_rx import uart_pkg::*; #(
    parameter logic [TC_W-1:0] TC_0 = TC_W'(TC_2400),
    parameter logic [TC_W-1:0] TC_1 = TC_W'(TC_4800),
    parameter logic [TC_W-1:0] TC_2 = TC_W'(TC_9600),
    parameter logic [TC_W-1:0] TC_3 = TC_W'(TC_19200)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic [1:0] baud_rate,
    output logic       tick
);

    logic [TC_W-1:0] cnt;
    logic [TC_W-1:0] tc;

    always_comb begin
        tc = TC_3;
        case (baud_rate)
            BAUD_2400:  tc = TC_0;
            BAUD_4800:  tc = TC_1;
            BAUD_9600:  tc = TC_2;
            BAUD_19200: tc = TC_3;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt >= tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == tc) && !clear;

endmodule

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - oversampling UART receiver with optional parity and error flags
module uart_rx_oversample import uart_pkg::*; #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    input  logic [1:0] baud_rate,
    input  logic       parity_en,
    input  logic       parity_odd,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       busy
);

    localparam int OSW = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] MID_TICK  = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] LAST_TICK = OSW'(OVERSAMPLE - 1);

    localparam logic [TC_W-1:0] TC_0 = TC_W'(tick_terminal(CLK_HZ, OVERSAMPLE, 2400));
    localparam logic [TC_W-1:0] TC_1 = TC_W'(tick_terminal(CLK_HZ, OVERSAMPLE, 4800));
    localparam logic [TC_W-1:0] TC_2 = TC_W'(tick_terminal(CLK_HZ, OVERSAMPLE, 9600));
    localparam logic [TC_W-1:0] TC_3 = TC_W'(tick_terminal(CLK_HZ, OVERSAMPLE, 19200));

    rx_state_t      state;
    logic           rx_meta;
    logic           rx_sync;
    logic [OSW-1:0] os_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;
    logic           par_bit;
    logic [1:0]     cfg_baud;
    logic           cfg_par_en;
    logic           cfg_par_odd;
    logic           tick;
    logic           tick_clear;

    // Holding the divider at zero while idle puts every tick a fixed phase after the falling edge.
    assign tick_clear = (state == IDLE);

    baud_tick_rx #(
        .TC_0(TC_0),
        .TC_1(TC_1),
        .TC_2(TC_2),
        .TC_3(TC_3)
    ) u_tick (
        .clock    (clock),
        .reset    (reset),
        .clear    (tick_clear),
        .baud_rate(cfg_baud),
        .tick     (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            state         <= IDLE;
            os_cnt        <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            par_bit       <= 1'b0;
            cfg_baud      <= BAUD_2400;
            cfg_par_en    <= 1'b0;
            cfg_par_odd   <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state       <= START;
                        busy        <= 1'b1;
                        os_cnt      <= '0;
                        cfg_baud    <= baud_rate;
                        cfg_par_en  <= parity_en;
                        cfg_par_odd <= parity_odd;
                    end
                end
                START: begin
                    if (tick) begin
                        if (os_cnt == MID_TICK) begin
                            os_cnt <= '0;
                            if (!rx_sync) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (os_cnt == LAST_TICK) begin
                            os_cnt  <= '0;
                            shift   <= {rx_sync, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= cfg_par_en ? PARITY : STOP;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        if (os_cnt == LAST_TICK) begin
                            os_cnt  <= '0;
                            par_bit <= rx_sync;
                            state   <= STOP;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (os_cnt == LAST_TICK) begin
                            os_cnt        <= '0;
                            state         <= IDLE;
                            busy          <= 1'b0;
                            data_out      <= shift;
                            data_valid    <= 1'b1;
                            framing_error <= ~rx_sync;
                            parity_error  <= cfg_par_en && ((^shift ^ par_bit) != cfg_par_odd);
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - scoreboard bench for uart_rx_oversample
module tb_uart_rx_oversample;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic [1:0] baud_rate;
    logic       parity_en;
    logic       parity_odd;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       busy;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   frames = 0;
    logic prev_dv = 1'b0;

    // 3.072 MHz makes every divisor exact: 80/40/20/10 clocks per tick.
    uart_rx_oversample #(
        .CLK_HZ    (3_072_000),
        .OVERSAMPLE(16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .baud_rate    (baud_rate),
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic int bit_len(input logic [1:0] b);
        case (b)
            2'b00:   return 1280;
            2'b01:   return 640;
            2'b10:   return 320;
            default: return 160;
        endcase
    endfunction

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [1:0] baud, input logic [7:0] data, input logic pen,
                              input logic pbit, input logic stop_bit, input int toggle_bit);
        int n;
        n = bit_len(baud);
        baud_rate = baud;
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) begin
            if (i == toggle_bit) baud_rate = ~baud;
            drive_bit(data[i], n);
        end
        if (pen) drive_bit(pbit, n);
        if (stop_bit) begin
            drive_bit(1'b1, n);
        end else begin
            // Low across the stop sample, then released before the break restart is qualified.
            drive_bit(1'b0, n * 10 / 16);
            drive_bit(1'b1, n - n * 10 / 16);
        end
        baud_rate = baud;
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (data_valid) begin
            frames++;
            check("dv_single_cycle", 32'(prev_dv), 32'(0));
            check("dv_expected_pending", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("data_out", 32'(data_out), 32'(e.data));
                check("parity_error", 32'(parity_error), 32'(e.perr));
                check("framing_error", 32'(framing_error), 32'(e.ferr));
            end
        end
        prev_dv = data_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        rx         = 1'b1;
        baud_rate  = 2'b11;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_data_out", 32'(data_out), 32'(0));
        check("rst_data_valid", 32'(data_valid), 32'(0));
        check("rst_parity_error", 32'(parity_error), 32'(0));
        check("rst_framing_error", 32'(framing_error), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        drive_bit(1'b1, 50);

        // 8N1 at 19200
        push(8'hA5, 1'b0, 1'b0);
        send_frame(2'b11, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
        drive_bit(1'b1, 320);

        // 9600 even parity, 0x07 has odd weight, parity bit 0 -> error
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        push(8'h07, 1'b1, 1'b0);
        send_frame(2'b10, 8'h07, 1'b1, 1'b0, 1'b1, -1);
        parity_en = 1'b0;
        drive_bit(1'b1, 640);

        // 2400 with stop bit low
        push(8'h3C, 1'b0, 1'b1);
        send_frame(2'b00, 8'h3C, 1'b0, 1'b0, 1'b0, -1);
        drive_bit(1'b1, 2560);

        // 4-tick glitch at 2400 (80 clocks per tick)
        baud_rate = 2'b00;
        drive_bit(1'b0, 160);
        check("glitch_busy_high", 32'(busy), 32'(1));
        drive_bit(1'b0, 160);
        drive_bit(1'b1, 360);
        check("glitch_busy_low_by_tick9", 32'(busy), 32'(0));
        drive_bit(1'b1, 1280);

        // back-to-back at 4800
        push(8'h55, 1'b0, 1'b0);
        push(8'hAA, 1'b0, 1'b0);
        send_frame(2'b01, 8'h55, 1'b0, 1'b0, 1'b1, -1);
        send_frame(2'b01, 8'hAA, 1'b0, 1'b0, 1'b1, -1);
        drive_bit(1'b1, 1280);

        // reset during bit 3 of 0xFF at 19200, then 0x12
        baud_rate = 2'b11;
        drive_bit(1'b0, 160);
        drive_bit(1'b1, 3 * 160 + 80);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("midframe_rst_data_out", 32'(data_out), 32'(0));
        check("midframe_rst_busy", 32'(busy), 32'(0));
        check("midframe_rst_dv", 32'(data_valid), 32'(0));
        drive_bit(1'b1, 80 + 5 * 160);
        push(8'h12, 1'b0, 1'b0);
        send_frame(2'b11, 8'h12, 1'b0, 1'b0, 1'b1, -1);
        drive_bit(1'b1, 320);

        // baud input switched to 4800 at bit 2 of a 9600 frame
        push(8'h9C, 1'b0, 1'b0);
        send_frame(2'b10, 8'h9C, 1'b0, 1'b0, 1'b1, 2);
        drive_bit(1'b1, 640);

        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        check("frames_delivered", 32'(frames), 32'(7));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
